// File: rtl/csa_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accumulator_ctrl
//
// This block accumulates a packet of unsigned operands with a carry-save adder.
// Each accepted beat is folded into a redundant (S, C) pair. It takes one cycle
// per beat, no matter how wide the accumulator is. After the last beat, a
// resolve phase ripples the remaining carry vector into S, one half-add step
// per cycle. The block then presents the packet sum, the operand count and an
// overflow flag on a valid/ready output handshake.
//
// Parameters
//   W      operand width
//   N_W    operand-count width. A packet holds at most 2^N_W-1 counted operands.
//
// Ports
//   clk        single clock, rising-edge active
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (IDLE/ACCUM, not in reset)
//   in_data    unsigned operand, W bits
//   in_last    final operand of the packet, sampled with the beat
//   out_valid  result available (DONE state)
//   out_ready  consumer accepts the result
//   out_sum    packet sum modulo 2^(W+N_W), registered
//   out_count  operands accepted in the packet, saturating, registered
//   out_ovf    packet exceeded 2^N_W-1 operands, registered
// ---------------------------------------------------------------------------
module csa_accumulator_ctrl #(
  parameter int W   = 4,
  parameter int N_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W+N_W-1:0]   out_sum,
  output logic [N_W-1:0]     out_count,
  output logic               out_ovf
);

  localparam int ACC_W = W + N_W;
  localparam logic [N_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] s_reg, s_next;
  logic [ACC_W-1:0] c_reg, c_next;
  logic [N_W-1:0]   cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             load_out;

  logic [ACC_W-1:0] out_sum_reg;
  logic [N_W-1:0]   out_count_reg;
  logic             out_ovf_reg;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] csa_sum, csa_carry;
  logic [ACC_W-1:0] ha_sum, ha_carry;

  assign x_ext = {{N_W{1'b0}}, in_data};

  // Per-bit adder cells. The carry vectors are produced already shifted up by
  // one bit. The carry out of the top bit is dropped, which gives the
  // modulo-2^ACC_W arithmetic.
  genvar gi;
  generate
    for (gi = 0; gi < ACC_W; gi++) begin : g_bit
      assign csa_sum[gi] = s_reg[gi] ^ c_reg[gi] ^ x_ext[gi];
      assign ha_sum[gi]  = s_reg[gi] ^ c_reg[gi];
      if (gi == 0) begin : g_lsb
        assign csa_carry[gi] = 1'b0;
        assign ha_carry[gi]  = 1'b0;
      end else begin : g_upper
        assign csa_carry[gi] = (s_reg[gi-1] & c_reg[gi-1]) |
                               (s_reg[gi-1] & x_ext[gi-1]) |
                               (c_reg[gi-1] & x_ext[gi-1]);
        assign ha_carry[gi]  = s_reg[gi-1] & c_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_out   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Reset parks the FSM in IDLE. in_ready is gated so that nothing is
        // advertised while rst is still asserted.
        in_ready = !rst;
        if (in_valid && !rst) begin
          s_next     = x_ext;
          c_next     = '0;
          cnt_next   = N_W'(1);
          ovf_next   = 1'b0;
          state_next = in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          s_next = csa_sum;
          c_next = csa_carry;
          if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + N_W'(1);
          end
          if (in_last) begin
            state_next = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        // Each step moves the pending carries at least one bit higher.
        // The carry vector is therefore empty after at most ACC_W steps.
        if (c_reg != '0) begin
          s_next = ha_sum;
          c_next = ha_carry;
        end else begin
          load_out   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg         <= '0;
      c_reg         <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      s_reg   <= s_next;
      c_reg   <= c_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      // The result registers capture only on entry to DONE. They keep the
      // last result in every other state.
      if (load_out) begin
        out_sum_reg   <= s_reg;
        out_count_reg <= cnt_reg;
        out_ovf_reg   <= ovf_reg;
      end
    end
  end

  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator_ctrl
//
// This bench drives the directed packets first and then randomized packets
// with valid gaps, garbage on the inputs while in_ready is low, and random
// out_ready hold-off. Each result is compared with the plain arithmetic sum,
// the saturated count and the overflow flag of the packet as it was sent.
// ---------------------------------------------------------------------------
module tb_csa_accumulator_ctrl;

  localparam int W     = 4;
  localparam int N_W   = 4;
  localparam int ACC_W = W + N_W;
  localparam int MAXC  = (1 << N_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic [N_W-1:0]   out_count;
  logic             out_ovf;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned pkt[$];

  always #5 clk = ~clk;

  csa_accumulator_ctrl #(.W(W), .N_W(N_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge. Holds the beat until it is accepted and returns at
  // the negedge that follows the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic scramble_inputs(input bit garbage);
    if (garbage) begin
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  // Sends every operand in pkt, then waits for the result, checks it, holds
  // out_ready low for 'hold' cycles and finally consumes the result.
  task automatic run_packet(input string name, input int hold, input int maxgap, input bit garbage);
    int unsigned n;
    int unsigned exp_sum;
    int unsigned exp_cnt;
    int unsigned exp_ovf;
    int          lat;
    int          bound;
    n       = pkt.size();
    exp_sum = 0;
    foreach (pkt[i]) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) @(negedge clk);
      exp_sum += pkt[i];
      send_beat(W'(pkt[i]), (i == int'(n) - 1));
    end
    exp_sum = exp_sum % (1 << ACC_W);
    exp_cnt = (n > MAXC) ? MAXC : n;
    exp_ovf = (n > MAXC) ? 1 : 0;

    lat = 0;
    while (!out_valid && lat < 40) begin
      scramble_inputs(garbage);
      @(negedge clk);
      lat++;
    end
    bound = (n == 1) ? 2 : ACC_W + 2;
    chk({name, "_latency_ok"}, 32'(lat <= bound), 32'(1));
    chk({name, "_sum"},   32'(out_sum),   32'(exp_sum));
    chk({name, "_count"}, 32'(out_count), 32'(exp_cnt));
    chk({name, "_ovf"},   32'(out_ovf),   32'(exp_ovf));
    chk({name, "_ready_low"}, 32'(in_ready), 32'(0));

    for (int h = 0; h < hold; h++) begin
      scramble_inputs(garbage);
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(out_valid), 32'(1));
      chk({name, "_hold_sum"},   32'(out_sum),   32'(exp_sum));
      chk({name, "_hold_count"}, 32'(out_count), 32'(exp_cnt));
      chk({name, "_hold_ready"}, 32'(in_ready),  32'(0));
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_consumed"},   32'(out_valid), 32'(0));
    chk({name, "_idle_ready"}, 32'(in_ready),  32'(1));
    chk({name, "_sum_held"},   32'(out_sum),   32'(exp_sum));
    $display("packet %s: beats=%0d sum=%0d count=%0d ovf=%0d latency=%0d", name, n, out_sum, out_count, out_ovf, lat);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", 32'(out_valid), 32'(0));
    chk("reset_ready", 32'(in_ready),  32'(0));
    chk("reset_sum",   32'(out_sum),   32'(0));
    chk("reset_count", 32'(out_count), 32'(0));
    chk("reset_ovf",   32'(out_ovf),   32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pkt = '{9};
    run_packet("single9", 0, 0, 0);

    pkt = '{15, 15, 15};
    run_packet("three15", 5, 0, 0);

    pkt.delete();
    repeat (15) pkt.push_back(15);
    run_packet("fifteen15", 1, 0, 0);

    pkt.push_back(15);
    run_packet("sixteen15", 1, 0, 0);

    // Interrupt a packet mid-ACCUM. The reset takes effect between clock edges.
    send_beat(W'(7), 1'b0);
    send_beat(W'(8), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_ready", 32'(in_ready),  32'(0));
    chk("midrst_sum",   32'(out_sum),   32'(0));
    chk("midrst_count", 32'(out_count), 32'(0));
    chk("midrst_ovf",   32'(out_ovf),   32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pkt = '{3, 4};
    run_packet("after_rst", 2, 0, 0);

    for (int p = 0; p < 40; p++) begin
      int len;
      len = int'($urandom_range(1, 20));
      pkt.delete();
      for (int b = 0; b < len; b++) pkt.push_back($urandom_range(0, 15));
      run_packet($sformatf("rand%0d", p), int'($urandom_range(0, 4)), 3, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
